// File: rtl/gpi_filter_pkg.sv
// Shared CSR constants and decode helper for the gpi_filter block.
// Latency: none (constants and a pure function).
// Backpressure: none.
package gpi_filter_pkg;

  // Register offsets relative to BASE_ADDR
  localparam logic [4:0] CSR_DBNC_OFF = 5'd0;
  localparam logic [4:0] CSR_IE_OFF   = 5'd1;
  localparam logic [4:0] CSR_IP_OFF   = 5'd2;

  // Debounce length loaded on reset, in prescaler ticks
  localparam logic [7:0] DBNC_RST = 8'h04;

  typedef enum logic [1:0] {
    SEL_DBNC,
    SEL_IE,
    SEL_IP,
    SEL_NONE
  } csr_sel_t;

  // Offset arithmetic is modulo 32, so a block placed near the top of the
  // address space wraps consistently with how the base is added.
  function automatic csr_sel_t csr_decode(input logic [4:0] addr,
                                          input logic [4:0] base);
    logic [4:0] off;
    off = addr - base;
    case (off)
      CSR_DBNC_OFF: csr_decode = SEL_DBNC;
      CSR_IE_OFF:   csr_decode = SEL_IE;
      CSR_IP_OFF:   csr_decode = SEL_IP;
      default:      csr_decode = SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/gpi_filter_ch.sv
// One debounced input channel: 2-flop synchroniser, tick-based counter, output flop.
// Latency: 3 clk from pin to out with dbnc==0, otherwise dbnc ticks after sync.
// Backpressure: none; the channel samples every cycle.
//
// Ports: clk, rst (sync, active-high), pin (raw async level), tick (shared
// prescaler strobe), dbnc (debounce length), out (debounced level), flip
// (combinational: out takes a new value on this clock edge).
module gpi_filter_ch (
  input  logic       clk,
  input  logic       rst,
  input  logic       pin,
  input  logic       tick,
  input  logic [7:0] dbnc,
  output logic       out,
  output logic       flip
);

  logic       in0;
  logic       in1;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic       out_nxt;
  logic [8:0] cnt_inc;

  // Nine bits so the compare against dbnc never sees a wrapped count
  assign cnt_inc = {1'b0, cnt} + 9'd1;

  always_comb begin
    out_nxt = out;
    cnt_nxt = cnt;
    if (in1 == out) begin
      cnt_nxt = '0;
    end else if (dbnc == 8'd0) begin
      // Bypass: follow the synchronised level directly
      out_nxt = in1;
      cnt_nxt = '0;
    end else if (tick) begin
      // >= rather than == so that lowering dbnc commits a channel already
      // past the new length on its next tick
      if (cnt_inc >= {1'b0, dbnc}) begin
        out_nxt = in1;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt_inc[7:0];
      end
    end
  end

  assign flip = (out_nxt != out);

  always_ff @(posedge clk) begin
    if (rst) begin
      in0 <= 1'b0;
      in1 <= 1'b0;
      out <= 1'b0;
      cnt <= '0;
    end else begin
      in0 <= pin;
      in1 <= in0;
      out <= out_nxt;
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/gpi_filter.sv
// Debounce filter for NUM_GPIOS raw inputs with CSR-programmable length and change interrupt.
// Latency: out 3 clk after pin (dbnc==0) or after dbnc prescaler ticks; csr_do 1 clk after csr_a.
// Backpressure: none; CSR writes complete in the strobe cycle, reads always respond.
//
// Ports: clk, rst (sync, active-high); csr_a/csr_di/csr_we/csr_do CSR bus
// (DBNC at BASE+0, IE at BASE+1, IP at BASE+2 write-1-to-clear);
// in (raw pins), out (debounced levels), irq (OR of IP & IE).
module gpi_filter
  import gpi_filter_pkg::*;
#(
  parameter logic [4:0] BASE_ADDR = 5'b0,
  parameter int         NUM_GPIOS = 8,
  parameter int         PRESCALE  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           csr_a,
  input  logic [7:0]           csr_di,
  input  logic                 csr_we,
  output logic [7:0]           csr_do,
  input  logic [NUM_GPIOS-1:0] in,
  output logic [NUM_GPIOS-1:0] out,
  output logic                 irq
);

  localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LOAD = PW'(PRESCALE - 1);

  logic [PW-1:0]        ps;
  logic                 tick;
  logic [7:0]           dbnc;
  logic [NUM_GPIOS-1:0] ie;
  logic [NUM_GPIOS-1:0] ip;
  logic [NUM_GPIOS-1:0] flips;
  logic [NUM_GPIOS-1:0] ip_clr;
  logic [7:0]           rd_dat;
  csr_sel_t             sel;

  // Prescaler: one tick every PRESCALE cycles, shared by all channels
  assign tick = (ps == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ps <= PS_LOAD;
    end else if (tick) begin
      ps <= PS_LOAD;
    end else begin
      ps <= ps - 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_GPIOS; i++) begin : g_ch
    gpi_filter_ch u_ch (
      .clk  (clk),
      .rst  (rst),
      .pin  (in[i]),
      .tick (tick),
      .dbnc (dbnc),
      .out  (out[i]),
      .flip (flips[i])
    );
  end

  assign sel    = csr_decode(csr_a, BASE_ADDR);
  assign ip_clr = (csr_we && sel == SEL_IP) ? csr_di[NUM_GPIOS-1:0] : '0;

  always_comb begin
    rd_dat = '0;
    case (sel)
      SEL_DBNC: rd_dat = dbnc;
      SEL_IE:   rd_dat[NUM_GPIOS-1:0] = ie;
      SEL_IP:   rd_dat[NUM_GPIOS-1:0] = ip;
      default:  rd_dat = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbnc   <= DBNC_RST;
      ie     <= '0;
      ip     <= '0;
      csr_do <= '0;
    end else begin
      if (csr_we && sel == SEL_DBNC) begin
        dbnc <= csr_di;
      end
      if (csr_we && sel == SEL_IE) begin
        ie <= csr_di[NUM_GPIOS-1:0];
      end
      // A new edge wins over a same-cycle clear of that bit
      ip     <= (ip & ~ip_clr) | flips;
      csr_do <= rd_dat;
    end
  end

  assign irq = |(ip & ie);

endmodule
